// File: rtl/rvsteel_irq_controller.sv
// Programmable interrupt controller: enable, edge/level trigger,
// pending tracking and claim/complete, folded onto irq_external.
module rvsteel_irq_controller #(
  parameter int          NUM_SOURCES   = 8,
  parameter int          SYNC_STAGES   = 2,
  parameter logic [31:0] RESET_TRIGGER = 32'd0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [4:0]             rw_address,
  output logic [31:0]            read_data,
  input  logic                   read_request,
  output logic                   read_response,
  input  logic [31:0]            write_data,
  input  logic [3:0]             write_strobe,
  input  logic                   write_request,
  output logic                   write_response,
  input  logic [NUM_SOURCES-1:0] irq_sources,
  output logic                   irq_external
);

  localparam int N = NUM_SOURCES;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0] prev_q;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] en_q, en_d;
  logic [N-1:0] trig_q, trig_d;
  logic [N-1:0] isv_q, isv_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         rresp_q, wresp_q, irq_q;

  logic [N-1:0] s, edge_det, pending, elig;
  logic [N-1:0] claim_mask, cmp_mask, w1c_mask, clr;
  logic [31:0]  wmask, en_wr, trig_wr, w1c_w;
  logic [5:0]   id;
  logic [2:0]   word;
  logic         wr_en, wr_trig, wr_w1c, wr_cmp, rd_claim;
  logic         unused_ok;

  assign word     = rw_address[4:2];
  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_det = s & ~prev_q;
  // Level sources show the live synchronised input; edge sources the latch.
  assign pending  = (pend_q & trig_q) | (s & ~trig_q);
  assign elig     = pending & en_q & ~isv_q;

  assign wmask = {{8{write_strobe[3]}}, {8{write_strobe[2]}},
                  {8{write_strobe[1]}}, {8{write_strobe[0]}}};
  assign wr_en   = write_request && (word == 3'd1);
  assign wr_trig = write_request && (word == 3'd2);
  assign wr_w1c  = write_request && (word == 3'd0);
  assign wr_cmp  = write_request && (word == 3'd4)
                   && write_strobe[0];
  assign rd_claim = read_request && (word == 3'd3);

  assign en_wr   = (32'(en_q) & ~wmask) | (write_data & wmask);
  assign trig_wr = (32'(trig_q) & ~wmask) | (write_data & wmask);
  assign w1c_w   = write_data & wmask;

  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (elig[i]) id = 6'(i + 1);
  end

  always_comb begin
    claim_mask = '0;
    cmp_mask   = '0;
    for (int i = 0; i < N; i++) begin
      claim_mask[i] = rd_claim && (id == 6'(i + 1));
      cmp_mask[i]   = wr_cmp && (write_data[5:0] == 6'(i + 1));
    end
  end

  always_comb begin
    en_d     = wr_en ? en_wr[N-1:0] : en_q;
    trig_d   = wr_trig ? trig_wr[N-1:0] : trig_q;
    w1c_mask = wr_w1c ? w1c_w[N-1:0] : '0;
    // A trigger flip discards stale pending; a fresh edge still wins.
    clr      = w1c_mask | claim_mask | (trig_d ^ trig_q);
    pend_d   = ((pend_q & ~clr) | edge_det) & trig_d;
    isv_d    = (isv_q & ~cmp_mask) | claim_mask;
  end

  always_comb begin
    rdata_d = '0;
    if (read_request) begin
      case (word)
        3'd0:    rdata_d = 32'(pending);
        3'd1:    rdata_d = 32'(en_q);
        3'd2:    rdata_d = 32'(trig_q);
        3'd3:    rdata_d = 32'(id);
        3'd5:    rdata_d = 32'(isv_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      trig_q  <= RESET_TRIGGER[N-1:0];
      isv_q   <= '0;
      rdata_q <= '0;
      rresp_q <= 1'b0;
      wresp_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync_q[0] <= irq_sources;
      for (int k = 1; k < SYNC_STAGES; k++)
        sync_q[k] <= sync_q[k-1];
      prev_q  <= s;
      pend_q  <= pend_d;
      en_q    <= en_d;
      trig_q  <= trig_d;
      isv_q   <= isv_d;
      rdata_q <= rdata_d;
      rresp_q <= read_request;
      wresp_q <= write_request;
      irq_q   <= |elig;
    end
  end

  // Responses in flight are suppressed while reset is held.
  assign read_response  = rresp_q & ~reset;
  assign write_response = wresp_q & ~reset;
  assign read_data      = rdata_q & {32{~reset}};
  assign irq_external   = irq_q;

  assign unused_ok = ^{rw_address[1:0], en_wr, trig_wr, w1c_w, wmask};

endmodule

// File: tb/tb_rvsteel_irq_controller.sv
// Directed bench for rvsteel_irq_controller with NUM_SOURCES=8,
// SYNC_STAGES=2; inputs change on negedge, outputs sampled on negedge.
module tb_rvsteel_irq_controller;

  localparam int N = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rw_address = '0;
  logic [31:0] read_data;
  logic        read_request = 1'b0;
  logic        read_response;
  logic [31:0] write_data = '0;
  logic [3:0]  write_strobe = '0;
  logic        write_request = 1'b0;
  logic        write_response;
  logic [N-1:0] irq_sources = '0;
  logic        irq_external;

  int total = 0;
  int bad   = 0;

  rvsteel_irq_controller #(
    .NUM_SOURCES(N),
    .SYNC_STAGES(2),
    .RESET_TRIGGER(32'd0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .rw_address(rw_address),
    .read_data(read_data),
    .read_request(read_request),
    .read_response(read_response),
    .write_data(write_data),
    .write_strobe(write_strobe),
    .write_request(write_request),
    .write_response(write_response),
    .irq_sources(irq_sources),
    .irq_external(irq_external)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input string tag, input logic [4:0] a,
                    input logic [31:0] exp);
    rw_address   = a;
    read_request = 1'b1;
    tick(1);
    read_request = 1'b0;
    chk({tag, "_rsp"}, 32'(read_response), 32'd1);
    chk(tag, read_data, exp);
  endtask

  task automatic wr(input string tag, input logic [4:0] a,
                    input logic [31:0] d, input logic [3:0] st);
    rw_address    = a;
    write_data    = d;
    write_strobe  = st;
    write_request = 1'b1;
    tick(1);
    write_request = 1'b0;
    chk({tag, "_wrsp"}, 32'(write_response), 32'd1);
  endtask

  initial begin
    // 1: reset state
    tick(3);
    reset = 1'b0;
    chk("rst_irq", 32'(irq_external), 32'd0);
    chk("rst_rrsp", 32'(read_response), 32'd0);
    rd("t1_en", 5'h04, 32'h0);
    tick(1);
    chk("t1_rsp_one_cycle", 32'(read_response), 32'd0);
    chk("t1_data_idle", read_data, 32'h0);
    rd("t1_trig", 5'h08, 32'h0);
    rd("t1_claim", 5'h0C, 32'h0);
    chk("t1_irq", 32'(irq_external), 32'd0);

    // 2: level sources, claim order, complete
    wr("t2_en", 5'h04, 32'hFF, 4'hF);
    wr("t2_trig", 5'h08, 32'h00, 4'hF);
    irq_sources = 8'h24;
    tick(2);
    chk("t2_irq_early", 32'(irq_external), 32'd0);
    tick(1);
    chk("t2_irq_on", 32'(irq_external), 32'd1);
    rd("t2_claim_a", 5'h0C, 32'd3);
    rd("t2_claim_b", 5'h0C, 32'd6);
    rd("t2_claim_c", 5'h0C, 32'd0);
    rd("t2_isv", 5'h14, 32'h24);
    chk("t2_irq_off", 32'(irq_external), 32'd0);
    wr("t2_cmp3", 5'h10, 32'd3, 4'hF);
    chk("t2_irq_lat", 32'(irq_external), 32'd0);
    tick(1);
    chk("t2_irq_again", 32'(irq_external), 32'd1);
    rd("t2_claim_d", 5'h0C, 32'd3);
    wr("t2_cmp3b", 5'h10, 32'd3, 4'hF);
    wr("t2_cmp6", 5'h10, 32'd6, 4'hF);
    irq_sources = '0;
    tick(4);

    // 3: edge source 0, single-cycle pulse
    wr("t3_trig", 5'h08, 32'h01, 4'hF);
    wr("t3_en", 5'h04, 32'h01, 4'hF);
    irq_sources = 8'h01;
    tick(1);
    irq_sources = '0;
    tick(4);
    rd("t3_pend", 5'h00, 32'h01);
    chk("t3_irq", 32'(irq_external), 32'd1);
    rd("t3_claim", 5'h0C, 32'd1);
    rd("t3_pend_clr", 5'h00, 32'h00);
    wr("t3_cmp", 5'h10, 32'd1, 4'hF);
    tick(2);
    chk("t3_irq_off", 32'(irq_external), 32'd0);

    // 4: edge arriving together with W1C -> set wins
    irq_sources = 8'h01;
    tick(1);
    irq_sources = '0;
    tick(4);
    rd("t4_pend_pre", 5'h00, 32'h01);
    irq_sources = 8'h01;
    tick(2);
    rw_address    = 5'h00;
    write_data    = 32'h1;
    write_strobe  = 4'hF;
    write_request = 1'b1;
    tick(1);
    write_request = 1'b0;
    chk("t4_wrsp", 32'(write_response), 32'd1);
    irq_sources = '0;
    tick(3);
    rd("t4_pend_set_wins", 5'h00, 32'h01);
    wr("t4_w1c", 5'h00, 32'h1, 4'hF);
    tick(1);
    rd("t4_pend_w1c", 5'h00, 32'h00);

    // 5: enable gating, strobes, reserved, bad complete
    wr("t5_trig", 5'h08, 32'h00, 4'hF);
    wr("t5_en0", 5'h04, 32'h00, 4'hF);
    irq_sources = 8'h04;
    tick(4);
    rd("t5_pend", 5'h00, 32'h04);
    chk("t5_irq_dis", 32'(irq_external), 32'd0);
    wr("t5_en_badlane", 5'h04, 32'h04, 4'b0010);
    rd("t5_en_unch", 5'h04, 32'h00);
    chk("t5_irq_still0", 32'(irq_external), 32'd0);
    wr("t5_en_lane0", 5'h04, 32'h04, 4'b0001);
    chk("t5_irq_lat", 32'(irq_external), 32'd0);
    tick(1);
    chk("t5_irq_on", 32'(irq_external), 32'd1);
    rd("t5_rsvd", 5'h1C, 32'h0);
    wr("t5_rsvd_wr", 5'h1C, 32'hFFFF_FFFF, 4'hF);
    rd("t5_en_after", 5'h04, 32'h04);
    rd("t5_trig_after", 5'h08, 32'h00);
    rd("t5_cmp_rd", 5'h10, 32'h0);
    rd("t5_claim", 5'h0C, 32'd3);
    wr("t5_cmp3f", 5'h10, 32'h3F, 4'hF);
    wr("t5_cmp9", 5'h10, 32'd9, 4'hF);
    rd("t5_isv", 5'h14, 32'h04);

    // 6: reset during an outstanding read
    rw_address   = 5'h0C;
    read_request = 1'b1;
    tick(1);
    read_request = 1'b0;
    reset        = 1'b1;
    irq_sources  = '0;
    #1;
    chk("t6_rsp_dropped", 32'(read_response), 32'd0);
    tick(1);
    reset = 1'b0;
    chk("t6_rsp_after", 32'(read_response), 32'd0);
    chk("t6_irq", 32'(irq_external), 32'd0);
    rd("t6_isv", 5'h14, 32'h0);
    rd("t6_pend", 5'h00, 32'h0);
    rd("t6_en", 5'h04, 32'h0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvsteel_irq_controller.md
Name: rvsteel_irq_controller

Overview:
Parametrised interrupt controller that aggregates up to 32 peripheral interrupt sources into the core's single irq_external line. It replaces the fixed one-source-per-line wiring of the SoC's fast interrupt vector with a programmable scheme: per-source enable, edge/level selection, pending tracking, and a claim/complete protocol. It sits on the system bus as a managed device, decoded as a 32-byte region.

Parameters:
NUM_SOURCES, 8, number of interrupt inputs; legal range 1..32.
SYNC_STAGES, 2, synchroniser flops per source input; legal range 1..3.
RESET_TRIGGER, 0, reset value of the TRIGGER register (bit=1 means edge).

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
rw_address  input  5  byte offset within the device region
read_data  output  32  register read data
read_request  input  1  bus read request
read_response  output  1  bus read response
write_data  input  32  bus write data
write_strobe  input  4  byte enables for write_data
write_request  input  1  bus write request
write_response  output  1  bus write response
irq_sources  input  NUM_SOURCES  raw interrupt inputs, possibly asynchronous
irq_external  output  1  interrupt request to the core

Behaviour:
- Interface: one clock, `clock`. Reset `reset` is synchronous and active-high. All state updates on the rising edge of `clock`.
- Reset values: read_data=0, read_response=0, write_response=0, irq_external=0; PENDING=0, ENABLE=0, IN_SERVICE=0, TRIGGER=RESET_TRIGGER, synchroniser and edge-history flops=0.
- Register map (offsets; bits at or above NUM_SOURCES read 0 and ignore writes):
  - 0x00 PENDING: read-only for level sources; write-1-to-clear for edge sources.
  - 0x04 ENABLE: read/write.
  - 0x08 TRIGGER: read/write; 1=rising edge, 0=active-high level.
  - 0x0C CLAIM: read returns the ID; side effect described below.
  - 0x10 COMPLETE: write-only; reads return 0.
  - 0x14 IN_SERVICE: read-only.
  - 0x18, 0x1C: reserved; read 0, writes ignored.
- Bus handshake:
  - read_response and write_response are asserted exactly one cycle after the corresponding request, for one cycle.
  - read_data is valid in the response cycle and is 0 otherwise.
  - Every request gets a response, including reserved offsets; there are no wait states.
  - Writes honour write_strobe per byte lane.
  - rw_address[1:0] is ignored (word access only).
- Synchronisation and edge detection:
  - Each source passes through SYNC_STAGES flops, giving s[i].
  - An edge is detected when s[i]=1 and the previous s[i]=0.
- PENDING update:
  - Level source: PENDING[i]=s[i], recomputed every cycle; W1C writes have no effect.
  - Edge source: a detected edge sets PENDING[i]; a W1C write or a claim clears it.
  - If an edge and a clear occur in the same cycle, the set wins.
- Eligibility and output:
  - eligible = PENDING & ENABLE & ~IN_SERVICE.
  - irq_external is registered and equals |eligible from the previous cycle, so it follows eligibility with one cycle of latency.
- CLAIM read:
  - ID = index+1 of the lowest-index eligible source, or 0 if none is eligible.
  - When ID≠0, the read sets IN_SERVICE[ID-1] and, if that source is edge-triggered, clears PENDING[ID-1].
  - The side effect is taken in the request cycle; ID is returned in the response cycle.
  - Back-to-back claims return successive sources.
- COMPLETE write (byte 0 must be strobed):
  - If write_data[5:0] is in 1..NUM_SOURCES, clear IN_SERVICE[write_data-1].
  - Out-of-range values or ID 0 are ignored.
  - A level source still asserted becomes eligible again the next cycle.
- TRIGGER change: writing TRIGGER clears PENDING for every bit that changed, which discards stale state.
- ENABLE=0: pending state continues to accumulate but the source is not eligible.
- Reset mid-transaction: any outstanding response is dropped, with no response after reset. All state returns to reset values.

Test Plan:
1. Reset, then read 0x04, 0x08, 0x0C → responses one cycle after each request; data 0, RESET_TRIGGER, 0; irq_external=0 throughout.
2. NUM_SOURCES=8, ENABLE=0xFF, TRIGGER=0x00; hold irq_sources=0x24 → after SYNC_STAGES+1 cycles irq_external=1. CLAIM→3, CLAIM→6, CLAIM→0, IN_SERVICE=0x24, irq_external=0. Write COMPLETE=3 with source still high → irq_external=1 again; CLAIM→3.
3. TRIGGER=0x01, ENABLE=0x01; pulse source 0 high for 1 cycle → PENDING=0x01, which holds after the input falls. CLAIM→1 and PENDING=0. COMPLETE=1 → irq_external stays 0.
4. Edge source 0 with PENDING=1: issue W1C 0x01 to 0x00 in the same cycle a new synchronised edge arrives → PENDING remains 0x01.
5. ENABLE=0x00 with level source 2 active → PENDING=0x04, irq_external=0. Write ENABLE=0x04 with write_strobe=4'b0010 → unchanged. Repeat with strobe 4'b0001 → irq_external=1 one cycle later. Access 0x1C → response 0, no state change. Write COMPLETE=0x3F → ignored.
6. Assert reset the cycle after a read request to CLAIM → no read_response. IN_SERVICE, PENDING, ENABLE=0; irq_external=0 on the following cycle.
